lsu_sq_drain: RTL and testbench
===============================

# lsu_sq_drain

Committed-store drain buffer on the memory side of the LSU store queue. It accepts stores that have retired from the store queue's commit port, holds them in order, and issues them one at a time as byte-enabled 64-bit write requests to the data memory. It completes each store on the memory response. With forwarding compiled in, it also reports whether a load's doubleword address hits a pending store.

## Interface
Parameters:
- DEPTH, 4: number of buffer entries; power of two, at least 2.
- XLEN, 64: address and data width.
- ID_W, 6: width of the instruction id carried for debug and error reporting.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- commit_i_valid  in  1  committed store offered.
- commit_i_ready  out  1  buffer can accept; equals not full.
- commit_id_i  in  ID_W  store instruction id.
- commit_paddr_i  in  XLEN  physical byte address.
- commit_size_i  in  2  size code: 0 = byte, 1 = half, 2 = word, 3 = dword.
- commit_data_i  in  XLEN  store data, right-aligned.
- mem_req_o_valid  out  1  write request valid.
- mem_req_o_ready  in  1  memory accepts the request.
- mem_req_addr_o  out  XLEN  doubleword-aligned address; paddr with bits [2:0] cleared.
- mem_req_wdata_o  out  64  data shifted into its byte lanes.
- mem_req_be_o  out  8  byte enables.
- mem_req_id_o  out  ID_W  id of the head entry.
- mem_rsp_i_valid  in  1  write response; one per accepted request.
- mem_rsp_err_i  in  1  the write failed.
- err_o  out  1  one-cycle pulse reporting a misaligned store or a memory error.
- err_id_o  out  ID_W  id of the failing store; valid while err_o is high.
- empty_o  out  1  no entries pending.
- count_o  out  $clog2(DEPTH)+1  number of occupied entries.
- fwd_paddr_i  in  XLEN  load address to look up.
- fwd_hit_o  out  1  a valid entry matches fwd_paddr_i[XLEN-1:3].

## Operation
- The buffer is a circular FIFO with head and tail pointers of $clog2(DEPTH) bits that wrap naturally, plus a separate count.
- Push occurs when commit_i_valid and commit_i_ready are both high; the entry is written at the tail.
- Pop occurs on mem_rsp_i_valid in state WAIT_RSP, and on discard of a misaligned entry.
- A push and a pop in the same cycle leave count unchanged.
- Lane formatting uses off = paddr[2:0]:
  - be = ((1 << (1 << size)) - 1) << off.
  - wdata = data << (8*off), truncated to 64 bits.
- A store is misaligned when off is not a multiple of (1 << size).
- The FSM has three states:
  - IDLE: if count > 0 and the head entry is aligned, go to REQ. If the head entry is misaligned, pulse err_o with its id, pop it, and stay in IDLE. It is never sent to memory.
  - REQ: mem_req_o_valid = 1. Address, data, byte enables and id are held stable until mem_req_o_ready. On the handshake, go to WAIT_RSP.
  - WAIT_RSP: mem_req_o_valid = 0. On mem_rsp_i_valid, pop the head and go to REQ if count after the pop is nonzero and the new head is aligned, otherwise to IDLE. If mem_rsp_err_i is set, pulse err_o with the head id; the entry is still popped, with no retry.
- At most one request is outstanding.
- mem_rsp_i_valid outside WAIT_RSP is ignored.

## Timing
- Reset values: commit_i_ready = 1, mem_req_o_valid = 0, mem_req_be_o = 0, mem_req_wdata_o = 0, mem_req_addr_o = 0, mem_req_id_o = 0, err_o = 0, err_id_o = 0, empty_o = 1, count_o = 0, fwd_hit_o = 0.
- Minimum latency is one cycle: a push at edge t into an empty buffer raises mem_req_o_valid after edge t+1.
- Back-to-back throughput: with ready and response both arriving in one cycle each, one store completes every 2 cycles.
- commit_i_ready depends only on registered count and is low when count == DEPTH. A pop in the same cycle does not raise it.
- count_o, empty_o and err_o are registered.
- fwd_hit_o is combinational from fwd_paddr_i and the registered entries. An entry being pushed in the current cycle is not visible to it.
- Reset asserted mid-operation, including in REQ or WAIT_RSP, clears all entries. mem_req_o_valid drops immediately. A later stray response is ignored.

## Configuration
- LSU_SQ_DRAIN_FWD_EN defined: the DEPTH-way doubleword address comparator drives fwd_hit_o.
- LSU_SQ_DRAIN_FWD_EN undefined: the comparator is not built, fwd_hit_o is tied to 0, and fwd_paddr_i is unused.

## Test plan
- Single store. Push paddr 0x1003, size 0, data 0xAB; memory ready immediately.
  - Required: request with addr 0x1000, be 0x08, wdata 0xAB000000 in the first cycle after the push.
  - A response two cycles later leaves empty_o = 1.
- Fill and wrap. Push 4 dword stores with memory ready held low.
  - Required: count_o = 4 and commit_i_ready = 0; a fifth push is not accepted.
  - Release ready: stores leave in order. Push 4 more: pointer wrap is handled and order is preserved.
- Misaligned store. Push a word store at paddr 0x2002, id 5, followed by an aligned store.
  - Required: err_o pulses with err_id_o = 5, no request is issued for it, and the aligned store is then issued.
- Memory error. Respond with mem_rsp_err_i = 1 to a store with id 9.
  - Required: err_o pulses with err_id_o = 9, the entry is popped, and the next store issues.
- Reset and forwarding.
  - Assert rstn low in WAIT_RSP: all outputs return to their reset values.
  - With the macro defined, after pushing 0x3008: fwd_paddr_i 0x300C gives hit = 1 and 0x3010 gives hit = 0.

Source files
------------

// File: rtl/lsu_sq_drain.sv
// Committed-store drain buffer: in-order FIFO of retired stores issued one at a time as
// byte-enabled doubleword writes. Optional load-forwarding lookup under LSU_SQ_DRAIN_FWD_EN.
module lsu_sq_drain #(
   parameter int DEPTH = 4,
   parameter int XLEN  = 64,
   parameter int ID_W  = 6
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     commit_i_valid,
   output logic                     commit_i_ready,
   input  logic [ID_W-1:0]          commit_id_i,
   input  logic [XLEN-1:0]          commit_paddr_i,
   input  logic [1:0]               commit_size_i,
   input  logic [XLEN-1:0]          commit_data_i,
   output logic                     mem_req_o_valid,
   input  logic                     mem_req_o_ready,
   output logic [XLEN-1:0]          mem_req_addr_o,
   output logic [63:0]              mem_req_wdata_o,
   output logic [7:0]               mem_req_be_o,
   output logic [ID_W-1:0]          mem_req_id_o,
   input  logic                     mem_rsp_i_valid,
   input  logic                     mem_rsp_err_i,
   output logic                     err_o,
   output logic [ID_W-1:0]          err_id_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o,
   input  logic [XLEN-1:0]          fwd_paddr_i,
   output logic                     fwd_hit_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP} state_t;

   logic [ID_W-1:0] r_id    [DEPTH];
   logic [XLEN-1:0] r_paddr [DEPTH];
   logic [1:0]      r_size  [DEPTH];
   logic [XLEN-1:0] r_data  [DEPTH];
   logic [AW-1:0]   r_head, r_tail;
   logic [CW-1:0]   r_count;
   logic            r_empty;

   state_t          r_state;
   logic            r_req_valid;
   logic [XLEN-1:0] r_req_addr;
   logic [63:0]     r_req_wdata;
   logic [7:0]      r_req_be;
   logic [ID_W-1:0] r_req_id;
   logic            r_err;
   logic [ID_W-1:0] r_err_id;

   logic            w_push, w_pop, w_use_nxt, w_nxt_avail;
   logic [AW-1:0]   w_nxt_idx;
   logic [CW-1:0]   w_count_nxt;
   logic [ID_W-1:0] w_sel_id;
   logic [XLEN-1:0] w_sel_paddr, w_sel_data;
   logic [1:0]      w_sel_size;
   logic [2:0]      w_sel_off;
   logic            w_sel_mis;
   logic [7:0]      w_sel_be;
   logic [63:0]     w_sel_wdata;

   function automatic logic f_misaligned(input logic [2:0] off, input logic [1:0] size);
      case (size)
         2'd0:    return 1'b0;
         2'd1:    return off[0];
         2'd2:    return |off[1:0];
         default: return |off;
      endcase
   endfunction

   function automatic logic [7:0] f_be(input logic [2:0] off, input logic [1:0] size);
      logic [7:0] m;
      case (size)
         2'd0:    m = 8'h01;
         2'd1:    m = 8'h03;
         2'd2:    m = 8'h0F;
         default: m = 8'hFF;
      endcase
      return m << off;
   endfunction

   assign commit_i_ready = (r_count != CW'(DEPTH));
   assign w_push         = commit_i_valid && commit_i_ready;
   assign w_nxt_idx      = AW'(r_head + 1'b1);

   // After a response the next head may be the store being pushed this very cycle.
   assign w_use_nxt   = (r_state == S_WAIT_RSP);
   assign w_nxt_avail = (r_count > CW'(1)) || w_push;

   always_comb begin
      w_sel_id    = r_id[r_head];
      w_sel_paddr = r_paddr[r_head];
      w_sel_size  = r_size[r_head];
      w_sel_data  = r_data[r_head];
      if (w_use_nxt) begin
         if (r_count > CW'(1)) begin
            w_sel_id    = r_id[w_nxt_idx];
            w_sel_paddr = r_paddr[w_nxt_idx];
            w_sel_size  = r_size[w_nxt_idx];
            w_sel_data  = r_data[w_nxt_idx];
         end else begin
            w_sel_id    = commit_id_i;
            w_sel_paddr = commit_paddr_i;
            w_sel_size  = commit_size_i;
            w_sel_data  = commit_data_i;
         end
      end
   end

   assign w_sel_off   = w_sel_paddr[2:0];
   assign w_sel_mis   = f_misaligned(w_sel_off, w_sel_size);
   assign w_sel_be    = f_be(w_sel_off, w_sel_size);
   assign w_sel_wdata = 64'(w_sel_data) << {w_sel_off, 3'b000};

   assign w_pop = ((r_state == S_IDLE) && (r_count != '0) && w_sel_mis) ||
                  ((r_state == S_WAIT_RSP) && mem_rsp_i_valid);

   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop)      w_count_nxt = r_count + CW'(1);
      else if (!w_push && w_pop) w_count_nxt = r_count - CW'(1);
   end

   // NOTE: the entry storage has no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_id[r_tail]    <= commit_id_i;
         r_paddr[r_tail] <= commit_paddr_i;
         r_size[r_tail]  <= commit_size_i;
         r_data[r_tail]  <= commit_data_i;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         r_empty <= 1'b1;
      end else begin
         if (w_push) r_tail <= AW'(r_tail + 1'b1);
         if (w_pop)  r_head <= w_nxt_idx;
         r_count <= w_count_nxt;
         r_empty <= (w_count_nxt == '0);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state     <= S_IDLE;
         r_req_valid <= 1'b0;
         r_req_addr  <= '0;
         r_req_wdata <= '0;
         r_req_be    <= '0;
         r_req_id    <= '0;
         r_err       <= 1'b0;
         r_err_id    <= '0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (r_count != '0) begin
                  if (w_sel_mis) begin
                     r_err    <= 1'b1;
                     r_err_id <= w_sel_id;
                  end else begin
                     r_state     <= S_REQ;
                     r_req_valid <= 1'b1;
                     r_req_addr  <= {w_sel_paddr[XLEN-1:3], 3'b000};
                     r_req_wdata <= w_sel_wdata;
                     r_req_be    <= w_sel_be;
                     r_req_id    <= w_sel_id;
                  end
               end
            end
            S_REQ: begin
               if (mem_req_o_ready) begin
                  r_state     <= S_WAIT_RSP;
                  r_req_valid <= 1'b0;
               end
            end
            S_WAIT_RSP: begin
               if (mem_rsp_i_valid) begin
                  if (mem_rsp_err_i) begin
                     r_err    <= 1'b1;
                     r_err_id <= r_req_id;
                  end
                  if (w_nxt_avail && !w_sel_mis) begin
                     r_state     <= S_REQ;
                     r_req_valid <= 1'b1;
                     r_req_addr  <= {w_sel_paddr[XLEN-1:3], 3'b000};
                     r_req_wdata <= w_sel_wdata;
                     r_req_be    <= w_sel_be;
                     r_req_id    <= w_sel_id;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem_req_o_valid = r_req_valid;
   assign mem_req_addr_o  = r_req_addr;
   assign mem_req_wdata_o = r_req_wdata;
   assign mem_req_be_o    = r_req_be;
   assign mem_req_id_o    = r_req_id;
   assign err_o           = r_err;
   assign err_id_o        = r_err_id;
   assign empty_o         = r_empty;
   assign count_o         = r_count;

`ifdef LSU_SQ_DRAIN_FWD_EN
   logic [DEPTH-1:0] r_vld;
   logic             w_fwd_hit;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_vld <= '0;
      end else begin
         if (w_pop)  r_vld[r_head] <= 1'b0;
         if (w_push) r_vld[r_tail] <= 1'b1;
      end
   end

   always_comb begin
      w_fwd_hit = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (r_vld[i] && (r_paddr[i][XLEN-1:3] == fwd_paddr_i[XLEN-1:3])) w_fwd_hit = 1'b1;
      end
   end

   assign fwd_hit_o = w_fwd_hit;
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^fwd_paddr_i;
   assign fwd_hit_o    = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_sq_drain.sv
// Directed bench for lsu_sq_drain: single store, fill/wrap, misaligned discard,
// memory error, mid-operation reset and forwarding lookup.
module tb_lsu_sq_drain;
   logic        clk = 1'b0;
   logic        rstn;
   logic        commit_i_valid;
   logic        commit_i_ready;
   logic [5:0]  commit_id_i;
   logic [63:0] commit_paddr_i;
   logic [1:0]  commit_size_i;
   logic [63:0] commit_data_i;
   logic        mem_req_o_valid;
   logic        mem_req_o_ready;
   logic [63:0] mem_req_addr_o;
   logic [63:0] mem_req_wdata_o;
   logic [7:0]  mem_req_be_o;
   logic [5:0]  mem_req_id_o;
   logic        mem_rsp_i_valid;
   logic        mem_rsp_err_i;
   logic        err_o;
   logic [5:0]  err_id_o;
   logic        empty_o;
   logic [2:0]  count_o;
   logic [63:0] fwd_paddr_i;
   logic        fwd_hit_o;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef LSU_SQ_DRAIN_FWD_EN
   localparam logic FWD = 1'b1;
`else
   localparam logic FWD = 1'b0;
`endif

   lsu_sq_drain #(.DEPTH(4), .XLEN(64), .ID_W(6)) dut (
      .clk(clk), .rstn(rstn),
      .commit_i_valid(commit_i_valid), .commit_i_ready(commit_i_ready),
      .commit_id_i(commit_id_i), .commit_paddr_i(commit_paddr_i),
      .commit_size_i(commit_size_i), .commit_data_i(commit_data_i),
      .mem_req_o_valid(mem_req_o_valid), .mem_req_o_ready(mem_req_o_ready),
      .mem_req_addr_o(mem_req_addr_o), .mem_req_wdata_o(mem_req_wdata_o),
      .mem_req_be_o(mem_req_be_o), .mem_req_id_o(mem_req_id_o),
      .mem_rsp_i_valid(mem_rsp_i_valid), .mem_rsp_err_i(mem_rsp_err_i),
      .err_o(err_o), .err_id_o(err_id_o), .empty_o(empty_o), .count_o(count_o),
      .fwd_paddr_i(fwd_paddr_i), .fwd_hit_o(fwd_hit_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [5:0] id, input logic [63:0] paddr,
                       input logic [1:0] size, input logic [63:0] data);
      commit_id_i    = id;
      commit_paddr_i = paddr;
      commit_size_i  = size;
      commit_data_i  = data;
      commit_i_valid = 1'b1;
      tick();
      commit_i_valid = 1'b0;
   endtask

   // Wait for a request, check its fields, accept it, then respond.
   task automatic serve(input logic [5:0] id, input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [7:0] be, input logic err);
      for (int i = 0; i < 20 && !mem_req_o_valid; i++) tick();
      check("req_valid", mem_req_o_valid, 1);
      check("req_id", mem_req_id_o, id);
      check("req_addr", mem_req_addr_o, addr);
      check("req_wdata", mem_req_wdata_o, wdata);
      check("req_be", mem_req_be_o, be);
      mem_req_o_ready = 1'b1;
      tick();
      mem_req_o_ready = 1'b0;
      check("req_drop", mem_req_o_valid, 0);
      mem_rsp_i_valid = 1'b1;
      mem_rsp_err_i   = err;
      tick();
      mem_rsp_i_valid = 1'b0;
      mem_rsp_err_i   = 1'b0;
      check("err_o", err_o, err);
      if (err) check("err_id", err_id_o, id);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"}, commit_i_ready, 1);
      check({tag, "_valid"}, mem_req_o_valid, 0);
      check({tag, "_be"}, mem_req_be_o, 0);
      check({tag, "_wdata"}, mem_req_wdata_o, 0);
      check({tag, "_addr"}, mem_req_addr_o, 0);
      check({tag, "_id"}, mem_req_id_o, 0);
      check({tag, "_err"}, err_o, 0);
      check({tag, "_err_id"}, err_id_o, 0);
      check({tag, "_empty"}, empty_o, 1);
      check({tag, "_count"}, count_o, 0);
      check({tag, "_hit"}, fwd_hit_o, 0);
   endtask

   initial begin
      rstn = 1'b0;
      commit_i_valid = 1'b0; commit_id_i = '0; commit_paddr_i = '0;
      commit_size_i = '0; commit_data_i = '0;
      mem_req_o_ready = 1'b0; mem_rsp_i_valid = 1'b0; mem_rsp_err_i = 1'b0;
      fwd_paddr_i = '0;
      tick(); tick();
      check_reset_values("rst");
      rstn = 1'b1;
      tick();

      // Single byte store at offset 3.
      push(6'd1, 64'h1003, 2'd0, 64'hAB);
      check("single_count", count_o, 1);
      tick();
      check("single_latency", mem_req_o_valid, 1);
      serve(6'd1, 64'h1000, 64'hAB00_0000, 8'h08, 1'b0);
      check("single_empty", empty_o, 1);

      // Fill with memory stalled, reject a fifth push, drain in order.
      push(6'd10, 64'h4000, 2'd3, 64'h1111_1111_1111_1111);
      push(6'd11, 64'h4008, 2'd3, 64'h2222_2222_2222_2222);
      push(6'd12, 64'h4010, 2'd3, 64'h3333_3333_3333_3333);
      push(6'd13, 64'h4018, 2'd3, 64'h4444_4444_4444_4444);
      check("full_count", count_o, 4);
      check("full_ready", commit_i_ready, 0);
      push(6'd14, 64'h4020, 2'd3, 64'h5555_5555_5555_5555);
      check("full_reject", count_o, 4);
      serve(6'd10, 64'h4000, 64'h1111_1111_1111_1111, 8'hFF, 1'b0);
      serve(6'd11, 64'h4008, 64'h2222_2222_2222_2222, 8'hFF, 1'b0);
      serve(6'd12, 64'h4010, 64'h3333_3333_3333_3333, 8'hFF, 1'b0);
      serve(6'd13, 64'h4018, 64'h4444_4444_4444_4444, 8'hFF, 1'b0);
      check("drain_empty", empty_o, 1);
      check("drain_count", count_o, 0);

      // Second pass after pointer wrap, mixed sizes and offsets.
      push(6'd20, 64'h5004, 2'd2, 64'hDEAD_BEEF);
      push(6'd21, 64'h5002, 2'd1, 64'h1234);
      push(6'd22, 64'h5007, 2'd0, 64'h5A);
      push(6'd23, 64'h5008, 2'd3, 64'h0123_4567_89AB_CDEF);
      check("wrap_count", count_o, 4);
      serve(6'd20, 64'h5000, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b0);
      serve(6'd21, 64'h5000, 64'h0000_0000_1234_0000, 8'h0C, 1'b0);
      serve(6'd22, 64'h5000, 64'h5A00_0000_0000_0000, 8'h80, 1'b0);
      serve(6'd23, 64'h5008, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0);
      check("wrap_empty", empty_o, 1);

      // Misaligned word store is discarded with an error, the next one issues.
      push(6'd5, 64'h2002, 2'd2, 64'h55);
      push(6'd6, 64'h2004, 2'd2, 64'h77);
      check("mis_err", err_o, 1);
      check("mis_err_id", err_id_o, 5);
      check("mis_no_req", mem_req_o_valid, 0);
      check("mis_count", count_o, 1);
      serve(6'd6, 64'h2000, 64'h0000_0077_0000_0000, 8'hF0, 1'b0);

      // Memory error on id 9; entry popped and id 10 issues straight after.
      push(6'd9, 64'h6000, 2'd3, 64'hCAFE);
      push(6'd10, 64'h6008, 2'd3, 64'hBEEF);
      serve(6'd9, 64'h6000, 64'hCAFE, 8'hFF, 1'b1);
      check("memerr_count", count_o, 1);
      check("memerr_next", mem_req_o_valid, 1);
      serve(6'd10, 64'h6008, 64'hBEEF, 8'hFF, 1'b0);
      check("memerr_empty", empty_o, 1);

      // Reset while waiting for a response, then a stray response.
      push(6'd30, 64'h7000, 2'd3, 64'h1234);
      for (int i = 0; i < 20 && !mem_req_o_valid; i++) tick();
      check("rst_req_valid", mem_req_o_valid, 1);
      mem_req_o_ready = 1'b1;
      tick();
      mem_req_o_ready = 1'b0;
      rstn = 1'b0;
      #1;
      check_reset_values("midrst");
      tick();
      rstn = 1'b1;
      mem_rsp_i_valid = 1'b1;
      tick();
      mem_rsp_i_valid = 1'b0;
      check("stray_count", count_o, 0);
      check("stray_err", err_o, 0);
      check("stray_valid", mem_req_o_valid, 0);

      // Forwarding lookup: an entry being pushed is not yet visible.
      commit_id_i = 6'd40; commit_paddr_i = 64'h3008; commit_size_i = 2'd3;
      commit_data_i = 64'h77; commit_i_valid = 1'b1;
      fwd_paddr_i = 64'h3008;
      #1;
      check("fwd_same_cycle", fwd_hit_o, 0);
      tick();
      commit_i_valid = 1'b0;
      fwd_paddr_i = 64'h300C;
      #1;
      check("fwd_hit", fwd_hit_o, FWD);
      fwd_paddr_i = 64'h3010;
      #1;
      check("fwd_miss", fwd_hit_o, 0);
      fwd_paddr_i = 64'h300C;
      serve(6'd40, 64'h3008, 64'h77, 8'hFF, 1'b0);
      #1;
      check("fwd_after_pop", fwd_hit_o, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
